// File: rtl/sfx_pkg.sv
// Shared types and the default tone table for the sound-effect sequencer.
// half_period() returns half-period clock counts at 100 MHz; 0 marks a rest.
package sfx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StNote,
        StGap
    } sfx_state_e;

    localparam int unsigned SFX_MOVE    = 0;
    localparam int unsigned SFX_CAPTURE = 1;
    localparam int unsigned SFX_CHECK   = 2;
    localparam int unsigned SFX_MATE    = 3;

    localparam int unsigned HP_W = 18;

    function automatic logic [HP_W-1:0] half_period(input int unsigned id,
                                                    input int unsigned idx);
        logic [HP_W-1:0] hp;
        hp = '0;
        case (id)
            SFX_MOVE: begin
                if (idx == 0) hp = 18'd125000;
            end
            SFX_CAPTURE: begin
                case (idx)
                    0:       hp = 18'd83333;
                    1:       hp = 18'd125000;
                    default: hp = '0;
                endcase
            end
            SFX_CHECK: begin
                if (idx < 3) hp = 18'd62500;
            end
            SFX_MATE: begin
                case (idx)
                    0:       hp = 18'd95602;
                    1:       hp = 18'd127551;
                    2:       hp = 18'd151515;
                    3:       hp = 18'd190840;
                    default: hp = '0;
                endcase
            end
            default: hp = '0;
        endcase
        return hp;
    endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave generator: toggles square every half_period cycles while en is high.
// clr returns the counter and output to 0 and has priority over en.
module sfx_tone_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic [17:0] half_period,
    output logic        square
);

    logic [31:0] tone_cnt_q, tone_cnt_d;
    logic        square_q, square_d;
    logic [31:0] hp_last;

    assign hp_last = 32'(half_period) - 32'd1;

    always_comb begin
        tone_cnt_d = tone_cnt_q;
        square_d   = square_q;
        if (clr) begin
            tone_cnt_d = '0;
            square_d   = 1'b0;
        end else if (en && (half_period != '0)) begin
            if (tone_cnt_q >= hp_last) begin
                tone_cnt_d = '0;
                square_d   = ~square_q;
            end else begin
                tone_cnt_d = tone_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_cnt_q <= '0;
            square_q   <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            square_q   <= square_d;
        end
    end

    assign square = square_q;

endmodule

// File: rtl/sfx_sequencer.sv
// Plays one of NUM_SFX tone sequences on a speaker pin; a higher or equal index
// trigger edge preempts the current effect, a lower one is ignored.
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int unsigned NUM_SFX       = 4,
    parameter int unsigned NOTES_PER_SFX = 4,
    parameter int unsigned NOTE_CYCLES   = 10_000_000,
    parameter int unsigned GAP_CYCLES    = 1_000_000,
    parameter int unsigned TONE_SHIFT    = 0,
    localparam int unsigned IdW          = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SFX-1:0] sfx_trig,
    input  logic               mute,
    output logic               speaker_out,
    output logic               busy,
    output logic [IdW-1:0]     playing_id
);

    localparam int unsigned NiW = (NOTES_PER_SFX > 1) ? $clog2(NOTES_PER_SFX) : 1;

    sfx_state_e         state_q, state_d;
    logic [NiW-1:0]     note_idx_q, note_idx_d;
    logic [31:0]        dur_q, dur_d;
    logic [IdW-1:0]     id_q, id_d;
    logic [NUM_SFX-1:0] trig_q;
    logic               mute_q;

    logic [NUM_SFX-1:0] rise;
    logic [IdW-1:0]     sel;
    logic               any_rise, accept;
    logic [HP_W-1:0]    hp;
    logic               tone_en, tone_clr, square;

    assign rise     = sfx_trig & ~trig_q;
    assign any_rise = |rise;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_SFX; i++) begin
            if (rise[i]) sel = IdW'(i);
        end
    end

    assign accept = any_rise && ((state_q == StIdle) || (sel >= id_q));

    always_comb begin
        state_d    = state_q;
        note_idx_d = note_idx_q;
        dur_d      = dur_q;
        id_d       = id_q;
        case (state_q)
            StIdle: ;
            StNote: begin
                if (dur_q == NOTE_CYCLES - 1) begin
                    state_d = StGap;
                    dur_d   = '0;
                end else begin
                    dur_d = dur_q + 32'd1;
                end
            end
            StGap: begin
                if (dur_q == GAP_CYCLES - 1) begin
                    dur_d = '0;
                    if (note_idx_q == NiW'(NOTES_PER_SFX - 1)) begin
                        state_d = StIdle;
                    end else begin
                        state_d    = StNote;
                        note_idx_d = note_idx_q + NiW'(1);
                    end
                end else begin
                    dur_d = dur_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        // An accepted trigger overrides normal progression, including sequence end.
        if (accept) begin
            state_d    = StNote;
            note_idx_d = '0;
            dur_d      = '0;
            id_d       = sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            note_idx_q <= '0;
            dur_q      <= '0;
            id_q       <= '0;
            trig_q     <= '0;
            mute_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            note_idx_q <= note_idx_d;
            dur_q      <= dur_d;
            id_q       <= id_d;
            trig_q     <= sfx_trig;
            mute_q     <= mute;
        end
    end

    assign hp       = half_period(32'(id_q), 32'(note_idx_q)) >> TONE_SHIFT;
    assign tone_en  = (state_q == StNote) && (hp != '0);
    // Every entry into a note starts from a cleared counter and a low output.
    assign tone_clr = accept || (state_q != StNote) || (state_d != StNote);

    sfx_tone_gen u_tone_gen (
        .clk         (clk),
        .rst         (rst),
        .en          (tone_en),
        .clr         (tone_clr),
        .half_period (hp),
        .square      (square)
    );

    assign speaker_out = square & ~mute_q;
    assign busy        = (state_q != StIdle);
    assign playing_id  = id_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Self-checking bench: each effect episode (busy high span) is scored against
// its expected length and speaker rising-edge count taken from a queue.
module tb_sfx_sequencer;

    localparam int unsigned NOTE_C = 100;
    localparam int unsigned GAP_C  = 10;
    localparam int unsigned SHIFT  = 10;
    localparam int          EFFECT = 4 * (NOTE_C + GAP_C);

    logic       clk;
    logic       rst;
    logic [3:0] sfx_trig;
    logic       mute;
    logic       speaker_out;
    logic       busy;
    logic [1:0] playing_id;

    sfx_sequencer #(
        .NUM_SFX       (4),
        .NOTES_PER_SFX (4),
        .NOTE_CYCLES   (NOTE_C),
        .GAP_CYCLES    (GAP_C),
        .TONE_SHIFT    (SHIFT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sfx_trig    (sfx_trig),
        .mute        (mute),
        .speaker_out (speaker_out),
        .busy        (busy),
        .playing_id  (playing_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int len;
        int edges;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Episode monitor: scores every busy span that ends without reset.
    int ep_len = 0;
    int ep_edges = 0;
    logic prev_spk = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            ep_len   = 0;
            ep_edges = 0;
            prev_spk = 1'b0;
        end else begin
            if (busy) begin
                ep_len++;
                if (speaker_out && !prev_spk) ep_edges++;
            end else if (ep_len != 0) begin
                if (exp_q.size() == 0) begin
                    check("extra_episode_len", ep_len, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("episode_len", ep_len, e.len);
                    check("episode_edges", ep_edges, e.edges);
                end
                ep_len   = 0;
                ep_edges = 0;
            end
            prev_spk = speaker_out;
        end
    end

    task automatic push_exp(input int len, input int edges);
        exp_t e;
        e.len   = len;
        e.edges = edges;
        exp_q.push_back(e);
    endtask

    // Trigger is sampled on the posedge between the two negedges.
    task automatic pulse(input int i);
        @(negedge clk);
        sfx_trig[i] = 1'b1;
        @(negedge clk);
        sfx_trig[i] = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("idle_within_budget", int'(busy), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        sfx_trig = 4'b0001;
        mute     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_speaker", int'(speaker_out), 0);
        check("rst_id", int'(playing_id), 0);

        // Trigger held through reset release is one edge; holding it plays once.
        push_exp(EFFECT, 0);
        rst = 1'b0;
        @(negedge clk);
        check("hold_busy_latency", int'(busy), 1);
        repeat (999) @(negedge clk);
        sfx_trig = '0;
        wait_idle(2000);
        check("hold_no_retrigger", int'(busy), 0);

        // Effect 0: hp=122 never toggles within a 100-cycle note.
        @(negedge clk);
        check("pre_trig_busy", int'(busy), 0);
        push_exp(EFFECT, 0);
        pulse(0);
        check("sfx0_busy_latency", int'(busy), 1);
        check("sfx0_id", int'(playing_id), 0);
        wait_idle(2000);

        // Effect 2: hp=61, one rising edge in each of three notes.
        push_exp(EFFECT, 3);
        pulse(2);
        check("sfx2_id", int'(playing_id), 2);
        wait_idle(2000);

        // Effect 3 ignores a lower trigger at 50, restarts on its own at 200.
        push_exp(200 + EFFECT, 2);
        pulse(3);
        repeat (49) @(negedge clk);
        sfx_trig[1] = 1'b1;
        @(negedge clk);
        sfx_trig[1] = 1'b0;
        check("ignore_low_id", int'(playing_id), 3);
        repeat (149) @(negedge clk);
        sfx_trig[3] = 1'b1;
        @(negedge clk);
        sfx_trig[3] = 1'b0;
        check("restart_busy", int'(busy), 1);
        check("restart_speaker", int'(speaker_out), 0);
        check("restart_id", int'(playing_id), 3);
        wait_idle(2000);

        // Effect 1 preempted by effect 2 after 30 cycles.
        push_exp(30 + EFFECT, 3);
        pulse(1);
        check("sfx1_id", int'(playing_id), 1);
        repeat (29) @(negedge clk);
        sfx_trig[2] = 1'b1;
        @(negedge clk);
        sfx_trig[2] = 1'b0;
        check("preempt_id", int'(playing_id), 2);
        wait_idle(2000);

        // Mute silences the pin without changing timing.
        mute = 1'b1;
        push_exp(EFFECT, 0);
        pulse(2);
        repeat (70) @(negedge clk);
        check("mute_speaker", int'(speaker_out), 0);
        check("mute_busy", int'(busy), 1);
        wait_idle(2000);
        mute = 1'b0;

        // Retrigger sampled on the final gap cycle keeps busy high.
        push_exp(2 * EFFECT, 0);
        pulse(0);
        repeat (EFFECT - 1) @(negedge clk);
        sfx_trig[0] = 1'b1;
        @(negedge clk);
        sfx_trig[0] = 1'b0;
        check("final_gap_busy", int'(busy), 1);
        wait_idle(3000);

        // Asynchronous reset mid-note clears outputs immediately.
        pulse(2);
        repeat (70) @(negedge clk);
        check("pre_rst_speaker", int'(speaker_out), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_speaker", int'(speaker_out), 0);
        check("async_rst_id", int'(playing_id), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_busy", int'(busy), 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
